usb3_ext_in_feeder: RTL and testbench
=====================================

USB3_EXT_IN_FEEDER -- requirements
Module: usb3_ext_in_feeder

Interface
REQ-001 Parameter MAX_WORDS, default 256, SHALL set the maximum 32-bit words per committed packet; legal range 1..511.
REQ-002 local_clk  in  1  sole clock (125 MHz local domain); all logic on rising edge.
REQ-003 reset_n  in  1  reset; synchronous, active-low.
REQ-004 s_data  in  32  stream word, byte 0 in bits [7:0].
REQ-005 s_valid  in  1  s_data/s_last/s_last_bytes valid.
REQ-006 s_last  in  1  final word of the transfer.
REQ-007 s_last_bytes  in  2  valid bytes in the final word; 0 means 4; ignored unless s_last.
REQ-008 s_ready  out  1  feeder accepts a beat this cycle.
REQ-009 buf_in_addr  out  9  protocol-layer IN buffer word address.
REQ-010 buf_in_data  out  32  write data.
REQ-011 buf_in_wren  out  1  write strobe, one cycle per word.
REQ-012 buf_in_ready  in  1  protocol layer has an empty IN buffer.
REQ-013 buf_in_commit  out  1  packet-complete request, level.
REQ-014 buf_in_commit_len  out  11  packet length in bytes.
REQ-015 buf_in_commit_ack  in  1  protocol layer acknowledge, level.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 pkt_count  out  16  committed packets, wraps at 65535 -> 0.

Function
REQ-018 FSM states SHALL be IDLE, FILL, COMMIT, RELEASE.
REQ-019 IDLE -> FILL when buf_in_ready=1; word counter and byte length cleared on entry.
REQ-020 s_ready SHALL be combinationally (state==FILL); high in no other state.
REQ-021 Beat accepted = s_valid & s_ready; gaps in s_valid SHALL NOT advance the address.
REQ-022 Beat accepted at edge T: at T+1 buf_in_wren=1, buf_in_addr=word index (0 for first beat of packet), buf_in_data=s_data; wren low otherwise.
REQ-023 Packet closes when accepted beat has s_last=1, or is word number MAX_WORDS (auto-split); FILL -> COMMIT at same edge.
REQ-024 Length: auto-split or non-final word = words*4; s_last word = (words-1)*4 + (s_last_bytes==0 ? 4 : s_last_bytes).
REQ-025 s_last on word MAX_WORDS SHALL produce a single commit using the s_last length rule.
REQ-026 buf_in_commit SHALL rise at T+2 (one cycle after the final wren) and hold, with commit_len stable, until commit_ack=1 is sampled.
REQ-027 On sampling commit_ack=1 in COMMIT: commit low next cycle, pkt_count+1, -> RELEASE.
REQ-028 RELEASE -> IDLE only when commit_ack=0 sampled; ack held high SHALL NOT cause a second count.
REQ-029 buf_in_ready changes outside IDLE SHALL be ignored.
REQ-030 commit_ack high while not in COMMIT SHALL be ignored.
REQ-031 After an auto-split the remainder of the transfer SHALL start a new packet at addr 0 once IDLE sees buf_in_ready=1.

Reset
REQ-032 With reset_n=0 at an edge: state IDLE; s_ready, buf_in_wren, buf_in_commit, busy=0; buf_in_addr, buf_in_data, buf_in_commit_len, pkt_count=0.
REQ-033 Reset mid-FILL or mid-COMMIT SHALL discard the partial packet; the next packet starts at addr 0 with no residual commit.

Verification
REQ-034 buf_in_ready=1, 3 beats, last with s_last_bytes=2 -> wren at addr 0,1,2; commit_len=10; commit held until ack; pkt_count=1.
REQ-035 MAX_WORDS=256, 300-word transfer -> commit len 1024, then after re-ready a second packet addr 0..43, len 176; pkt_count=2.
REQ-036 buf_in_ready=0 for 50 cycles with s_valid=1 -> s_ready=0 throughout; s_ready=1 one cycle after ready sampled high.
REQ-037 ack after 5 cycles, held 3 cycles -> commit high exactly until ack sampled; pkt_count +1 once; busy high until ack low.
REQ-038 reset_n=0 after 2 accepted beats, then new 1-beat packet (s_last_bytes=0) -> wren at addr 0, commit_len=4.
REQ-039 s_valid toggling every other cycle, 4 beats -> addresses 0..3 contiguous, commit_len=16.

Source files
------------

// File: rtl/usb3_ext_in_feeder.sv
// usb3_ext_in_feeder: packs a 32-bit stream into protocol-layer IN buffers and commits each packet
module usb3_ext_in_feeder #(
   parameter int MAX_WORDS = 256
) (
   input  logic        local_clk,
   input  logic        reset_n,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   input  logic        s_last,
   input  logic [1:0]  s_last_bytes,
   output logic        s_ready,
   output logic [8:0]  buf_in_addr,
   output logic [31:0] buf_in_data,
   output logic        buf_in_wren,
   input  logic        buf_in_ready,
   output logic        buf_in_commit,
   output logic [10:0] buf_in_commit_len,
   input  logic        buf_in_commit_ack,
   output logic        busy,
   output logic [15:0] pkt_count
);
   typedef enum logic [1:0] {IDLE, FILL, COMMIT, RELEASE} state_t;
   state_t state, state_nxt;
   logic [8:0] word_idx;
   logic accept, close, ack_hs;
   logic [10:0] beat_len;
   assign s_ready = state == FILL;
   assign busy = state != IDLE;
   assign accept = s_valid & s_ready;
   assign close = s_last | (word_idx == 9'(MAX_WORDS - 1));
   assign ack_hs = (state == COMMIT) & buf_in_commit & buf_in_commit_ack;
   // byte length if this beat closes the packet; a short final word only counts when s_last
   assign beat_len = {word_idx, 2'b00} + ((s_last && s_last_bytes != 2'd0) ? {9'd0, s_last_bytes} : 11'd4);
   // state register
   always_ff @(posedge local_clk) begin
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;
   end
   // next state; commit ack only counts once the commit request is actually up
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = buf_in_ready ? FILL : IDLE;
         FILL:    state_nxt = (accept && close) ? COMMIT : FILL;
         COMMIT:  state_nxt = ack_hs ? RELEASE : COMMIT;
         RELEASE: state_nxt = buf_in_commit_ack ? RELEASE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   // buffer write port, packet length capture, commit request and packet counter
   always_ff @(posedge local_clk) begin
      if (!reset_n) begin
         word_idx          <= '0;
         buf_in_addr       <= '0;
         buf_in_data       <= '0;
         buf_in_wren       <= 1'b0;
         buf_in_commit     <= 1'b0;
         buf_in_commit_len <= '0;
         pkt_count         <= '0;
      end else begin
         buf_in_wren <= accept;
         if (state == IDLE && buf_in_ready) begin
            word_idx          <= '0;
            buf_in_commit_len <= '0;
         end
         if (accept) begin
            buf_in_addr <= word_idx;
            buf_in_data <= s_data;
            word_idx    <= word_idx + 9'd1;
            if (close) buf_in_commit_len <= beat_len;
         end
         if (state == COMMIT) buf_in_commit <= !ack_hs;
         if (ack_hs) pkt_count <= pkt_count + 16'd1;
      end
   end
endmodule

// File: tb/tb_usb3_ext_in_feeder.sv
// tb_usb3_ext_in_feeder: random transfers against a packet-splitting model with a scoreboard monitor
module tb_usb3_ext_in_feeder;
   localparam int MW = 256;
   logic        local_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic [1:0]  s_last_bytes = '0;
   logic        s_ready;
   logic [8:0]  buf_in_addr;
   logic [31:0] buf_in_data;
   logic        buf_in_wren;
   logic        buf_in_ready = 1'b0;
   logic        buf_in_commit;
   logic [10:0] buf_in_commit_len;
   logic        buf_in_commit_ack = 1'b0;
   logic        busy;
   logic [15:0] pkt_count;
   int checks = 0, failures = 0;
   logic [8:0]  exp_addr[$];
   logic [31:0] exp_data[$];
   logic [10:0] exp_len[$];
   int model_pkts = 0;
   bit rand_ready = 0, ready_force = 0, ack_en = 1;
   int ack_dly = -1, ack_hold = -1;
   bit prev_commit = 0, prev_wren = 0, ack_pend = 0;
   logic [15:0] hs_cnt = '0;
   logic [10:0] held_len = '0;

   usb3_ext_in_feeder #(.MAX_WORDS(MW)) dut (
      .local_clk(local_clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid),
      .s_last(s_last), .s_last_bytes(s_last_bytes), .s_ready(s_ready),
      .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
      .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
      .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack),
      .busy(busy), .pkt_count(pkt_count));

   always #4 local_clk = ~local_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // buffer-ready source: forced level or random toggling
   initial forever begin
      @(posedge local_clk); #1;
      buf_in_ready = rand_ready ? ($urandom_range(0, 2) != 0) : ready_force;
   end

   // protocol-layer acknowledge responder
   initial begin
      int d, h;
      forever begin
         @(posedge local_clk); #1;
         if (ack_en && reset_n && buf_in_commit) begin
            d = ack_dly < 0 ? $urandom_range(0, 4) : ack_dly;
            h = ack_hold < 0 ? $urandom_range(1, 3) : ack_hold;
            repeat (d) begin @(posedge local_clk); #1; end
            buf_in_commit_ack = 1'b1;
            repeat (h) begin @(posedge local_clk); #1; end
            buf_in_commit_ack = 1'b0;
         end
      end
   end

   // monitor: pops expected writes and commits as the DUT presents them
   always @(negedge local_clk) begin
      if (!reset_n) begin
         prev_commit = 0; prev_wren = 0; ack_pend = 0; hs_cnt = '0;
      end else begin
         if (buf_in_wren) begin
            if (exp_addr.size() == 0) chk("unexpected_write_addr", {23'd0, buf_in_addr}, 32'hffff_ffff);
            else begin
               chk("write_addr", {23'd0, buf_in_addr}, {23'd0, exp_addr.pop_front()});
               chk("write_data", buf_in_data, exp_data.pop_front());
            end
         end
         if (ack_pend) begin
            chk("commit_drop_after_ack", {31'd0, buf_in_commit}, 0);
            chk("pkt_count", {16'd0, pkt_count}, {16'd0, hs_cnt});
         end else if (prev_commit && !buf_in_commit)
            chk("commit_dropped_without_ack", 0, 1);
         if (buf_in_commit && !prev_commit) begin
            chk("commit_one_after_last_wren", {31'd0, prev_wren}, 1);
            if (exp_len.size() == 0) chk("unexpected_commit_len", {21'd0, buf_in_commit_len}, 32'hffff_ffff);
            else chk("commit_len", {21'd0, buf_in_commit_len}, {21'd0, exp_len.pop_front()});
            held_len = buf_in_commit_len;
         end else if (buf_in_commit && buf_in_commit_len !== held_len)
            chk("commit_len_stable", {21'd0, buf_in_commit_len}, {21'd0, held_len});
         if (buf_in_commit_ack) chk("busy_while_ack", {31'd0, busy}, 1);
         ack_pend = buf_in_commit && buf_in_commit_ack;
         if (ack_pend) hs_cnt = hs_cnt + 16'd1;
         prev_commit = buf_in_commit;
         prev_wren = buf_in_wren;
      end
   end

   task automatic put_beat(input logic [31:0] d, input logic l, input logic [1:0] lb, input int gap);
      int n = 0;
      bit acc = 0;
      if (gap == 2) begin s_valid = 1'b0; @(posedge local_clk); #1; end
      if (gap == 1) while ($urandom_range(0, 2) == 0) begin s_valid = 1'b0; @(posedge local_clk); #1; end
      s_valid = 1'b1; s_data = d; s_last = l; s_last_bytes = lb;
      do begin acc = s_ready; @(posedge local_clk); #1; n++; end while (!acc && n < 4000);
      if (!acc) chk("beat_accept_timeout", 0, 1);
      s_valid = 1'b0;
   endtask

   // model: a transfer of n words splits into ceil(n/MW) packets; only the last uses s_last_bytes
   task automatic send_xfer(input int n, input logic [1:0] lb, input int gap);
      logic [31:0] d[];
      int k, r;
      d = new[n];
      foreach (d[i]) d[i] = $urandom;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(9'(i % MW));
         exp_data.push_back(d[i]);
      end
      k = (n - 1) / MW;
      r = n - k * MW;
      for (int i = 0; i < k; i++) exp_len.push_back(11'(MW * 4));
      exp_len.push_back(11'((r - 1) * 4 + (lb == 2'd0 ? 4 : int'(lb))));
      model_pkts += k + 1;
      for (int i = 0; i < n; i++) put_beat(d[i], i == n - 1, (i == n - 1) ? lb : 2'($urandom), gap);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_addr.size() != 0 || exp_len.size() != 0 || buf_in_commit || buf_in_commit_ack) && n < 6000) begin
         @(negedge local_clk); n++;
      end
      chk("drain_timeout", n < 6000, 1);
      chk("pkt_count_total", {16'd0, pkt_count}, 32'(model_pkts % 65536));
   endtask

   task automatic reset_dut();
      @(negedge local_clk); #1;
      reset_n = 1'b0;
      model_pkts = 0;
      repeat (2) @(negedge local_clk);
      chk("rst_s_ready", {31'd0, s_ready}, 0);
      chk("rst_wren", {31'd0, buf_in_wren}, 0);
      chk("rst_commit", {31'd0, buf_in_commit}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_addr", {23'd0, buf_in_addr}, 0);
      chk("rst_data", buf_in_data, 0);
      chk("rst_len", {21'd0, buf_in_commit_len}, 0);
      chk("rst_pkt_count", {16'd0, pkt_count}, 0);
      @(posedge local_clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int n;
      logic [31:0] d0, d1;
      reset_dut();
      // held-off buffer: stream stalls, then opens one cycle after ready is sampled
      s_valid = 1'b1; s_data = $urandom;
      repeat (50) begin
         @(negedge local_clk);
         chk("s_ready_low_while_not_ready", {31'd0, s_ready}, 0);
      end
      ready_force = 1;
      @(negedge local_clk);
      s_valid = 1'b0;
      chk("s_ready_before_sample", {31'd0, s_ready}, 0);
      @(negedge local_clk);
      chk("s_ready_after_sample", {31'd0, s_ready}, 1);
      #1;
      send_xfer(3, 2'd2, 0);
      drain();
      send_xfer(4, 2'd0, 2);
      drain();
      ack_dly = 5; ack_hold = 3;
      send_xfer(2, 2'd1, 0);
      drain();
      ack_dly = -1; ack_hold = -1;
      send_xfer(300, 2'd0, 0);
      drain();
      send_xfer(256, 2'd3, 1);
      send_xfer(512, 2'd2, 0);
      drain();
      rand_ready = 1;
      repeat (12) begin
         n = ($urandom_range(0, 4) == 0) ? $urandom_range(250, 520) : $urandom_range(1, 40);
         send_xfer(n, 2'($urandom), 1);
      end
      drain();
      rand_ready = 0;
      // reset in the middle of a fill discards the partial packet
      d0 = $urandom; d1 = $urandom;
      exp_addr.push_back(9'd0); exp_data.push_back(d0);
      exp_addr.push_back(9'd1); exp_data.push_back(d1);
      put_beat(d0, 1'b0, 2'd0, 0);
      put_beat(d1, 1'b0, 2'd0, 0);
      reset_dut();
      send_xfer(1, 2'd0, 0);
      drain();
      // reset while a commit is outstanding leaves no residual commit
      ack_en = 0;
      send_xfer(3, 2'd3, 0);
      n = 0;
      while (!buf_in_commit && n < 100) begin @(negedge local_clk); n++; end
      chk("commit_seen_before_reset", {31'd0, buf_in_commit}, 1);
      repeat (3) @(negedge local_clk);
      reset_dut();
      ack_en = 1;
      @(negedge local_clk);
      chk("no_residual_commit", {31'd0, buf_in_commit}, 0);
      #1;
      send_xfer(1, 2'd2, 1);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
